// File: rtl/memory_address_generator.sv
// Address generator: PC, MAR and IR registers with an active-low one-hot mode select
// onto a combinational address bus, plus a sticky fault flag for conflicting selects.
module memory_address_generator #(
   parameter int LOG = 0
) (
   input  logic        clk,
   input  logic        _mr,
   input  logic        _addrmode_pc,
   input  logic        _addrmode_register,
   input  logic        _addrmode_direct,
   input  logic        phaseFetch,
   input  logic        phaseExec,
   input  logic [15:0] rom_data,
   input  logic [7:0]  data_in,
   input  logic        _marlo_in,
   input  logic        _marhi_in,
   input  logic        _mar_inc,
   input  logic        _pc_load,
   input  logic [15:0] pc_load_value,
   output logic [15:0] address,
   output logic [15:0] pc,
   output logic [15:0] mar,
   output logic        addr_valid,
   output logic        addr_fault
);

   logic [15:0] pc_q, pc_d;
   logic [15:0] mar_q, mar_d;
   logic [15:0] ir_q, ir_d;
   logic        fault_q, fault_d;
   logic [2:0]  sel;
   logic        multi_sel;

   // Selects are active-low; bit 2 = PC, bit 1 = MAR, bit 0 = IR.
   assign sel       = {~_addrmode_pc, ~_addrmode_register, ~_addrmode_direct};
   assign multi_sel = (sel != 3'b000) && !$onehot(sel);

   always_comb begin
      ir_d = ir_q;
      if (phaseFetch) begin
         ir_d = rom_data;
      end
   end

   always_comb begin
      pc_d = pc_q;
      if (phaseExec) begin
         if (!_pc_load) begin
            pc_d = pc_load_value;
         end else begin
            pc_d = pc_q + 16'd1;
         end
      end
   end

   // Byte loads take priority over increment; an unloaded byte holds.
   always_comb begin
      mar_d = mar_q;
      if (!_marlo_in || !_marhi_in) begin
         if (!_marlo_in) begin
            mar_d[7:0] = data_in;
         end
         if (!_marhi_in) begin
            mar_d[15:8] = data_in;
         end
      end else if (!_mar_inc) begin
         mar_d = mar_q + 16'd1;
      end
   end

   always_comb begin
      fault_d = fault_q | multi_sel;
   end

   always_ff @(posedge clk or negedge _mr) begin
      if (!_mr) begin
         pc_q    <= 16'h0000;
         mar_q   <= 16'h0000;
         ir_q    <= 16'h0000;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         mar_q   <= mar_d;
         ir_q    <= ir_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      address    = 16'h0000;
      addr_valid = 1'b0;
      case (sel)
         3'b100: begin
            address    = pc_q;
            addr_valid = 1'b1;
         end
         3'b010: begin
            address    = mar_q;
            addr_valid = 1'b1;
         end
         3'b001: begin
            address    = ir_q;
            addr_valid = 1'b1;
         end
         default: begin
            address    = 16'h0000;
            addr_valid = 1'b0;
         end
      endcase
   end

   assign pc         = pc_q;
   assign mar        = mar_q;
   assign addr_fault = fault_q;

   // Simulation-only trace; has no effect on the registered logic.
   if (LOG != 0) begin : g_trace
      always @(posedge clk) begin
         if (_mr) begin
            $display("mag: sel=%b addr=%h pc %h->%h mar %h->%h ir %h->%h fault=%b",
                     sel, address, pc_q, pc_d, mar_q, mar_d, ir_q, ir_d, fault_d);
         end
      end
   end

endmodule

// File: tb/tb_memory_address_generator.sv
// Directed bench: expected values are queued as stimulus is driven and checked
// against the DUT after each step.
module tb_memory_address_generator;

   logic        clk = 1'b0;
   logic        _mr;
   logic        _addrmode_pc, _addrmode_register, _addrmode_direct;
   logic        phaseFetch, phaseExec;
   logic [15:0] rom_data;
   logic [7:0]  data_in;
   logic        _marlo_in, _marhi_in, _mar_inc, _pc_load;
   logic [15:0] pc_load_value;
   logic [15:0] address, pc, mar;
   logic        addr_valid, addr_fault;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   memory_address_generator #(.LOG(0)) dut (
      .clk               (clk),
      ._mr               (_mr),
      ._addrmode_pc      (_addrmode_pc),
      ._addrmode_register(_addrmode_register),
      ._addrmode_direct  (_addrmode_direct),
      .phaseFetch        (phaseFetch),
      .phaseExec         (phaseExec),
      .rom_data          (rom_data),
      .data_in           (data_in),
      ._marlo_in         (_marlo_in),
      ._marhi_in         (_marhi_in),
      ._mar_inc          (_mar_inc),
      ._pc_load          (_pc_load),
      .pc_load_value     (pc_load_value),
      .address           (address),
      .pc                (pc),
      .mar               (mar),
      .addr_valid        (addr_valid),
      .addr_fault        (addr_fault)
   );

   always #5 clk = ~clk;

   task automatic push(input logic [15:0] e);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [15:0] obs);
      logic [15:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s observed %h but scoreboard empty", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      _mr = 1'b0;
      _addrmode_pc = 1'b1; _addrmode_register = 1'b1; _addrmode_direct = 1'b1;
      phaseFetch = 1'b0; phaseExec = 1'b0;
      rom_data = 16'h0000; data_in = 8'h00;
      _marlo_in = 1'b1; _marhi_in = 1'b1; _mar_inc = 1'b1; _pc_load = 1'b1;
      pc_load_value = 16'h0000;

      // Reset state, no mode selected
      #3;
      push(16'h0000); chk("rst_pc", pc);
      push(16'h0000); chk("rst_mar", mar);
      push(16'h0000); chk("rst_addr", address);
      push(16'h0000); chk("rst_valid", {15'd0, addr_valid});
      push(16'h0000); chk("rst_fault", {15'd0, addr_fault});
      tick();
      _mr = 1'b1;

      // PC counting via address bus
      _addrmode_pc = 1'b0;
      #1;
      push(16'h0000); chk("pc_addr0", address);
      push(16'h0001); chk("pc_valid", {15'd0, addr_valid});
      phaseExec = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         push(16'(i));
         tick();
         chk("pc_count", address);
      end

      // PC load, wrap and hold
      _pc_load = 1'b0; pc_load_value = 16'hFFFF;
      push(16'hFFFF); tick(); chk("pc_ld_ffff", pc);
      _pc_load = 1'b1;
      push(16'h0000); tick(); chk("pc_wrap", pc);
      _pc_load = 1'b0; pc_load_value = 16'h1234;
      push(16'h1234); tick(); chk("pc_jump", pc);
      phaseExec = 1'b0; pc_load_value = 16'h5555;
      push(16'h1234); tick(); chk("pc_hold", pc);
      _pc_load = 1'b1;

      // MAR byte loads, increment, load-over-increment
      _addrmode_pc = 1'b1; _addrmode_register = 1'b0;
      data_in = 8'hAB; _marhi_in = 1'b0;
      push(16'hAB00); tick(); chk("mar_hi", mar);
      _marhi_in = 1'b1; data_in = 8'hFF; _marlo_in = 1'b0;
      push(16'hABFF); tick(); chk("mar_lo_addr", address);
      _marlo_in = 1'b1; _mar_inc = 1'b0;
      push(16'hAC00); tick(); chk("mar_inc_carry", address);
      _marlo_in = 1'b0; data_in = 8'h10;
      push(16'hAC10); tick(); chk("mar_ld_wins", mar);
      _marhi_in = 1'b0; _mar_inc = 1'b1; data_in = 8'hFF;
      push(16'hFFFF); tick(); chk("mar_both", mar);
      _marhi_in = 1'b1; _marlo_in = 1'b1; _mar_inc = 1'b0;
      push(16'h0000); tick(); chk("mar_wrap", mar);
      _mar_inc = 1'b1;

      // IR fetch and hold
      phaseFetch = 1'b1; rom_data = 16'hBEEF;
      tick();
      phaseFetch = 1'b0;
      _addrmode_register = 1'b1; _addrmode_direct = 1'b0;
      #1;
      push(16'hBEEF); chk("ir_addr", address);
      rom_data = 16'h1111;
      push(16'hBEEF); tick(); chk("ir_hold", address);

      // Conflicting selects: fault is sticky but registers keep updating
      _addrmode_pc = 1'b0; phaseExec = 1'b1;
      #1;
      push(16'h0000); chk("multi_addr", address);
      push(16'h0000); chk("multi_valid", {15'd0, addr_valid});
      push(16'h0000); chk("fault_pre_edge", {15'd0, addr_fault});
      tick();
      push(16'h0001); chk("fault_set", {15'd0, addr_fault});
      push(16'h1235); chk("pc_upd_fault", pc);
      phaseExec = 1'b0; _addrmode_direct = 1'b1;
      tick();
      push(16'h1235); chk("fix_addr", address);
      push(16'h0001); chk("fault_sticky", {15'd0, addr_fault});
      #2; _mr = 1'b0; #1;
      push(16'h0000); chk("fault_clr", {15'd0, addr_fault});
      _mr = 1'b1;

      // Asynchronous reset mid-cycle, updates blocked while held
      _pc_load = 1'b0; pc_load_value = 16'h0042; phaseExec = 1'b1;
      push(16'h0042); tick(); chk("pc_42", pc);
      _pc_load = 1'b1;
      #2; _mr = 1'b0; #1;
      push(16'h0000); chk("async_rst_pc", pc);
      push(16'h0000); tick(); chk("rst_blocks", pc);
      push(16'h0000); chk("rst_addr_sel", address);
      #2; _mr = 1'b1;
      push(16'h0001); tick(); chk("post_rst_pc", pc);

      // Fetch and exec on the same edge
      phaseFetch = 1'b1; rom_data = 16'h1357;
      push(16'h0002); tick(); chk("both_pc", pc);
      phaseFetch = 1'b0; phaseExec = 1'b0;
      _addrmode_pc = 1'b1; _addrmode_direct = 1'b0;
      #1;
      push(16'h1357); chk("both_ir", address);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/memory_address_generator.md
MEMORY_ADDRESS_GENERATOR -- requirements
Module: memory_address_generator

Interface
REQ-001 Parameter: LOG, default 0; nonzero SHALL enable $display tracing of address selection and register updates, with no effect on function.
REQ-002 Port: clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 Port: _mr  input  1  master reset, asynchronous, active-low.
REQ-004 Port: _addrmode_pc  input  1  active-low select of PC onto address bus.
REQ-005 Port: _addrmode_register  input  1  active-low select of MAR onto address bus.
REQ-006 Port: _addrmode_direct  input  1  active-low select of IR direct address onto address bus.
REQ-007 Port: phaseFetch  input  1  fetch phase indicator.
REQ-008 Port: phaseExec  input  1  execute phase indicator.
REQ-009 Port: rom_data  input  16  instruction ROM bits [15:0], direct-address field.
REQ-010 Port: data_in  input  8  data bus byte for MAR loads.
REQ-011 Port: _marlo_in  input  1  active-low load of MAR[7:0].
REQ-012 Port: _marhi_in  input  1  active-low load of MAR[15:8].
REQ-013 Port: _mar_inc  input  1  active-low MAR increment.
REQ-014 Port: _pc_load  input  1  active-low PC load (jump).
REQ-015 Port: pc_load_value  input  16  jump target.
REQ-016 Port: address  output  16  memory address bus.
REQ-017 Port: pc  output  16  program counter value.
REQ-018 Port: mar  output  16  memory address register value.
REQ-019 Port: addr_valid  output  1  high when exactly one address mode is selected.
REQ-020 Port: addr_fault  output  1  sticky flag: multiple modes were selected at a clock edge.

Function
REQ-021 IR: on clk rise with phaseFetch=1, ir SHALL load rom_data; otherwise ir SHALL hold.
REQ-022 PC: on clk rise with phaseExec=1 and _pc_load=0, pc SHALL load pc_load_value.
REQ-023 PC: on clk rise with phaseExec=1 and _pc_load=1, pc SHALL increment by 1, wrapping 16'hFFFF -> 16'h0000.
REQ-024 PC: with phaseExec=0, pc SHALL hold regardless of _pc_load.
REQ-025 MAR: _marlo_in=0 SHALL load mar[7:0]; _marhi_in=0 SHALL load mar[15:8]; both low SHALL load data_in into both bytes in the same cycle.
REQ-026 MAR: _mar_inc=0 with both load strobes high SHALL increment mar by 1, 16-bit wrap (16'h00FF -> 16'h0100, 16'hFFFF -> 16'h0000).
REQ-027 MAR: any load strobe low SHALL suppress increment that cycle; loads win, and an unloaded byte holds.
REQ-028 address SHALL be combinational from current register state: pc if only _addrmode_pc low, mar if only _addrmode_register low, ir if only _addrmode_direct low.
REQ-029 No mode selected: address=16'h0000 and addr_valid=0.
REQ-030 Two or more modes selected: address=16'h0000, addr_valid=0, and addr_fault SHALL set at the next clk rise.
REQ-031 addr_fault SHALL remain set until _mr asserts; it SHALL NOT block register updates.
REQ-032 Selection latency zero: address SHALL follow enable changes with no clock delay; register updates are visible on address the same cycle after the edge.
REQ-033 phaseFetch and phaseExec both high SHALL perform both IR load and PC update on the same edge.

Reset
REQ-034 _mr=0 SHALL immediately and asynchronously clear pc, mar, ir to 16'h0000 and addr_fault to 0, independent of clk.
REQ-035 While _mr=0, all register updates SHALL be blocked; address SHALL still reflect the selection logic (16'h0000 for any single mode).
REQ-036 Reset asserted mid-instruction SHALL discard pending loads/increments; first edge after release SHALL act on inputs at that edge only.

Verification
REQ-037 Reset then three exec edges, _addrmode_pc=0 -> address 0000, 0001, 0002, 0003; addr_valid=1.
REQ-038 pc=16'hFFFF, exec edge -> pc=16'h0000; exec edge with _pc_load=0, pc_load_value=16'h1234 -> pc=16'h1234; _pc_load=0 with phaseExec=0 -> pc unchanged.
REQ-039 data_in=8'hAB with _marhi_in=0, then 8'hFF with _marlo_in=0, then _mar_inc=0, _addrmode_register=0 -> address ABFF then AC00; _mar_inc=0 with _marlo_in=0, data_in=8'h10 -> mar=16'hAC10.
REQ-040 Fetch edge with rom_data=16'hBEEF, then _addrmode_direct=0 -> address BEEF; later rom_data change without fetch -> address stays BEEF.
REQ-041 _addrmode_pc=0 and _addrmode_direct=0 over one edge -> address 0000, addr_valid=0, addr_fault=1 after edge and stays 1 after selection corrected; _mr pulse -> addr_fault=0.
REQ-042 _mr asserted between clock edges with pc=16'h0042 -> pc=16'h0000 immediately, before next clk rise.
